ppi_control_unit: RTL

PPI_CONTROL_UNIT -- requirements
Module: ppi_control_unit

---
 rtl/ppi_pkg.sv | 29 ++
 rtl/ppi_if.sv | 22 ++
 rtl/ppi_sync.sv | 31 +++
 rtl/ppi_control_unit.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/ppi_pkg.sv
// Shared constants for the PPI control unit: register addresses, control-word
// bit positions, reset control word and FSM state encoding.
package ppi_pkg;

   localparam logic [1:0] ADDR_PA   = 2'd0;
   localparam logic [1:0] ADDR_PB   = 2'd1;
   localparam logic [1:0] ADDR_PC   = 2'd2;
   localparam logic [1:0] ADDR_CTRL = 2'd3;

   localparam int CW_MODE_SET = 7;
   localparam int CW_A_DIR    = 4;
   localparam int CW_CU_DIR   = 3;
   localparam int CW_B_DIR    = 1;
   localparam int CW_CL_DIR   = 0;

   localparam logic [7:0] CW_RESET = 8'h9B;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACTIVE = 2'd1,
      ST_COMMIT = 2'd2
   } state_t;

   // Only mode 0 is implemented; any other group mode bits flag an error.
   function automatic logic mode_unsupported(input logic [7:0] word);
      return (word[6:5] != 2'b00) || word[2];
   endfunction

endpackage

// File: rtl/ppi_if.sv
// CPU-side bus of the PPI: strobes, address, write data and registered read data.
interface ppi_if;

   logic       cs_n;
   logic       wr_n;
   logic       rd_n;
   logic [1:0] addr;
   logic [7:0] d_in;
   logic [7:0] d_out;
   logic       d_oe;

   modport master (
      output cs_n, wr_n, rd_n, addr, d_in,
      input  d_out, d_oe
   );

   modport slave (
      input  cs_n, wr_n, rd_n, addr, d_in,
      output d_out, d_oe
   );

endinterface

// File: rtl/ppi_sync.sv
// Multi-bit flop-chain synchronizer; each bit resets to 1 (inactive strobe level).
module ppi_sync #(
   parameter int SYNC_STAGES = 2,
   parameter int WIDTH       = 1
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] async_in,
   output logic [WIDTH-1:0] sync_out
);

   generate
      for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
         logic [SYNC_STAGES-1:0] chain_reg;

         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
               chain_reg <= '1;
            end else begin
               chain_reg[0] <= async_in[gi];
               for (int i = 1; i < SYNC_STAGES; i++) begin
                  chain_reg[i] <= chain_reg[i-1];
               end
            end
         end

         assign sync_out[gi] = chain_reg[SYNC_STAGES-1];
      end
   endgenerate

endmodule

// File: rtl/ppi_control_unit.sv
// Mode-0 PPI control unit: synchronized CPU writes are captured, then committed
// to port latches / direction control one cycle later; reads are registered.
module ppi_control_unit
   import ppi_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       reset_n,
   ppi_if.slave       bus,
   input  logic [7:0] pa_in,
   input  logic [7:0] pb_in,
   input  logic [7:0] pc_in,
   output logic [7:0] pa_out,
   output logic [7:0] pb_out,
   output logic [7:0] pc_out,
   output logic       a_dir,
   output logic       b_dir,
   output logic       cu_dir,
   output logic       cl_dir,
   output logic       port_en,
   output logic       mode_err
);

   logic [2:0] strobe_raw;
   logic [2:0] strobe_sync;
   logic       cs_sync, wr_sync, rd_sync;

   state_t     state_reg, state_next;
   logic       capture_en, commit_en, read_en;

   logic [1:0] addr_reg;
   logic [7:0] data_reg;
   logic [7:0] pa_out_reg, pb_out_reg, pc_out_reg, ctrl_word_reg;
   logic       a_dir_reg, b_dir_reg, cu_dir_reg, cl_dir_reg;
   logic       port_en_reg, mode_err_reg;
   logic [7:0] d_out_reg, read_data;
   logic       d_oe_reg;

   assign strobe_raw = {bus.cs_n, bus.wr_n, bus.rd_n};

   ppi_sync #(
      .SYNC_STAGES (SYNC_STAGES),
      .WIDTH       (3)
   ) u_sync (
      .clk      (clk),
      .reset_n  (reset_n),
      .async_in (strobe_raw),
      .sync_out (strobe_sync)
   );

   assign cs_sync = strobe_sync[2];
   assign wr_sync = strobe_sync[1];
   assign rd_sync = strobe_sync[0];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state_reg <= ST_IDLE;
      else          state_reg <= state_next;
   end

   // ACTIVE is only entered with wr low, so wr high there is the rising edge.
   // cs is deliberately ignored once ACTIVE so a late cs release cannot abort.
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE:   if (!cs_sync && !wr_sync) state_next = ST_ACTIVE;
         ST_ACTIVE: if (wr_sync)              state_next = ST_COMMIT;
         ST_COMMIT:                           state_next = ST_IDLE;
         default:                             state_next = ST_IDLE;
      endcase
   end

   always_comb begin
      capture_en = (state_reg == ST_ACTIVE);
      commit_en  = (state_reg == ST_COMMIT);
      read_en    = (state_reg == ST_IDLE) && !cs_sync && !rd_sync && wr_sync;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         addr_reg <= '0;
         data_reg <= '0;
      end else if (capture_en) begin
         addr_reg <= bus.addr;
         data_reg <= bus.d_in;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pa_out_reg    <= 8'h00;
         pb_out_reg    <= 8'h00;
         pc_out_reg    <= 8'h00;
         ctrl_word_reg <= CW_RESET;
         a_dir_reg     <= 1'b1;
         b_dir_reg     <= 1'b1;
         cu_dir_reg    <= 1'b1;
         cl_dir_reg    <= 1'b1;
         port_en_reg   <= 1'b0;
         mode_err_reg  <= 1'b0;
      end else if (commit_en) begin
         case (addr_reg)
            ADDR_PA: pa_out_reg <= data_reg;
            ADDR_PB: pb_out_reg <= data_reg;
            ADDR_PC: pc_out_reg <= data_reg;
            default: begin
               if (data_reg[CW_MODE_SET]) begin
                  a_dir_reg     <= data_reg[CW_A_DIR];
                  cu_dir_reg    <= data_reg[CW_CU_DIR];
                  b_dir_reg     <= data_reg[CW_B_DIR];
                  cl_dir_reg    <= data_reg[CW_CL_DIR];
                  pa_out_reg    <= 8'h00;
                  pb_out_reg    <= 8'h00;
                  pc_out_reg    <= 8'h00;
                  port_en_reg   <= 1'b1;
                  ctrl_word_reg <= data_reg;
                  if (mode_unsupported(data_reg)) mode_err_reg <= 1'b1;
               end else begin
                  pc_out_reg[data_reg[3:1]] <= data_reg[0];
               end
            end
         endcase
      end
   end

   always_comb begin
      read_data = ctrl_word_reg;
      case (bus.addr)
         ADDR_PA: read_data = a_dir_reg ? pa_in : pa_out_reg;
         ADDR_PB: read_data = b_dir_reg ? pb_in : pb_out_reg;
         ADDR_PC: read_data = {cu_dir_reg ? pc_in[7:4] : pc_out_reg[7:4],
                               cl_dir_reg ? pc_in[3:0] : pc_out_reg[3:0]};
         default: read_data = ctrl_word_reg;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         d_out_reg <= 8'h00;
         d_oe_reg  <= 1'b0;
      end else begin
         d_oe_reg <= read_en;
         if (read_en) d_out_reg <= read_data;
      end
   end

   assign bus.d_out = d_out_reg;
   assign bus.d_oe  = d_oe_reg;
   assign pa_out    = pa_out_reg;
   assign pb_out    = pb_out_reg;
   assign pc_out    = pc_out_reg;
   assign a_dir     = a_dir_reg;
   assign b_dir     = b_dir_reg;
   assign cu_dir    = cu_dir_reg;
   assign cl_dir    = cl_dir_reg;
   assign port_en   = port_en_reg;
   assign mode_err  = mode_err_reg;

endmodule
